bfp_comp_gearbox: RTL

Packs variable-width BFP-compressed IQ chunks (two REs per beat, plus the 8-bit exponent on the first beat of each PRB) into a byte-ordered 64-bit AXI-Stream for O-RAN U-plane transmit. It sits after the BFP compressor and before the U-plane framer. It is the transmit-side counterpart of the decompression gearbox. Per packet it emits `tuser` carrying `udCompHdr` and sets `tkeep`/`tlast` on the final, zero-padded word.

---
 rtl/bfp_comp_gearbox_if.sv | 35 +++
 rtl/bfp_comp_gearbox.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bfp_comp_gearbox_if.sv
// Stream bundle for bfp_comp_gearbox.
//   din_*    : variable-width BFP chunk input (valid/ready, last, width and user sideband)
//   m_axis_* : byte-ordered 64-bit AXI-Stream output (tdata/tkeep/tlast/tuser)
// Modports:
//   slave  : the gearbox view (consumes din_*, produces m_axis_*)
//   master : the environment view (produces din_*, consumes m_axis_*)
interface bfp_comp_gearbox_if;
    logic [3:0]  din_width;
    logic [63:0] din_data;
    logic        din_valid;
    logic        din_ready;
    logic        din_last;
    logic [31:0] din_user;

    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [39:0] m_axis_tuser;

    modport slave (
        input  din_width, din_data, din_valid, din_last, din_user,
        output din_ready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport master (
        output din_width, din_data, din_valid, din_last, din_user,
        input  din_ready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/bfp_comp_gearbox.sv
// BFP compression gearbox: packs variable-width IQ chunks (two REs per beat, plus the
// 8-bit exponent on the first beat of each PRB) MSB-first into a 128-bit accumulator and
// drains it as byte-ordered 64-bit AXI-Stream words (first wire byte in lane 0).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : din_* chunk input and m_axis_* stream output
//   err_partial_prb : one-cycle pulse when a packet ends part-way through a PRB
module bfp_comp_gearbox (
    input  logic               clk,
    input  logic               rst_n,
    bfp_comp_gearbox_if.slave  bus,
    output logic               err_partial_prb
);

    logic [127:0] acc_q, acc_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [2:0]   state_q, state_d;
    logic         pend_last_q, pend_last_d;
    logic         sync_n_q, sync_n_d;
    logic [3:0]   width_q, width_d;
    logic [31:0]  user_q, user_d;
    logic [63:0]  tdata_q, tdata_d;
    logic [7:0]   tkeep_q, tkeep_d;
    logic         tvalid_q, tvalid_d;
    logic         tlast_q, tlast_d;
    logic [39:0]  tuser_q, tuser_d;
    logic         err_q, err_d;

    logic [3:0]   cur_w;
    logic [4:0]   chunk_n;
    logic         drain;
    logic         din_ready;
    logic         accept;
    logic [127:0] acc_base;
    logic [5:0]   cnt_base;
    logic [127:0] chunk_mask;
    logic [127:0] chunk_placed;
    logic [7:0]   place_sh;
    logic [3:0]   last_bytes;

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        pend_last_d  = pend_last_q;
        sync_n_d     = sync_n_q;
        width_d      = width_q;
        user_d       = user_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        err_d        = 1'b0;
        chunk_mask   = '0;
        chunk_placed = '0;
        place_sh     = '0;
        last_bytes   = '0;

        // Width comes straight from the input on a packet's first beat.
        cur_w = sync_n_q ? width_q : bus.din_width;
        if (cur_w == 4'd0) begin
            chunk_n = 5'd16;
        end else if (state_q == 3'd0) begin
            chunk_n = {1'b0, cur_w} + 5'd2;
        end else begin
            chunk_n = {1'b0, cur_w};
        end

        drain = ((cnt_q >= 5'd16) || (pend_last_q && (cnt_q != 5'd0)))
                && (!tvalid_q || bus.m_axis_tready);
        // No new beats while a packet is flushing, so packets never share a word.
        din_ready = rst_n && !pend_last_q && ((cnt_q < 5'd16) || drain);
        accept    = bus.din_valid && din_ready;

        acc_base = acc_q;
        cnt_base = {1'b0, cnt_q};
        if (drain) begin
            acc_base = acc_q << 64;
            cnt_base = (cnt_q >= 5'd16) ? ({1'b0, cnt_q} - 6'd16) : 6'd0;
            for (int i = 0; i < 8; i++) begin
                tdata_d[8*i +: 8] = acc_q[127-8*i -: 8];
            end
            tvalid_d = 1'b1;
            tuser_d  = {width_q, (width_q != 4'd0) ? 4'b0001 : 4'b0000, user_q};
            if (pend_last_q && (cnt_q <= 5'd16)) begin
                last_bytes  = 4'(({1'b0, cnt_q} + 6'd1) >> 1);
                tkeep_d     = 8'((9'd1 << last_bytes) - 9'd1);
                tlast_d     = 1'b1;
                pend_last_d = 1'b0;
            end else begin
                tkeep_d = 8'hFF;
                tlast_d = 1'b0;
            end
        end else if (bus.m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        acc_d = acc_base;
        cnt_d = cnt_base[4:0];
        if (accept) begin
            // Right-aligned chunk is moved so its MSB lands just below the fill point.
            chunk_mask   = (128'd1 << {chunk_n, 2'b00}) - 128'd1;
            place_sh     = 8'd128 - {1'b0, chunk_n, 2'b00} - {cnt_base, 2'b00};
            chunk_placed = ({64'd0, bus.din_data} & chunk_mask) << place_sh;
            acc_d        = acc_base | chunk_placed;
            cnt_d        = 5'(cnt_base + {1'b0, chunk_n});
            if (bus.din_last) begin
                state_d     = 3'd0;
                pend_last_d = 1'b1;
                err_d       = (state_q != 3'd5);
            end else begin
                state_d = (state_q == 3'd5) ? 3'd0 : state_q + 3'd1;
            end
            sync_n_d = !bus.din_last;
            if (!sync_n_q) begin
                width_d = bus.din_width;
                user_d  = bus.din_user;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= '0;
            pend_last_q <= 1'b0;
            sync_n_q    <= 1'b0;
            width_q     <= '0;
            user_q      <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            pend_last_q <= pend_last_d;
            sync_n_q    <= sync_n_d;
            width_q     <= width_d;
            user_q      <= user_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            err_q       <= err_d;
        end
    end

    assign bus.din_ready     = din_ready;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tkeep  = tkeep_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign err_partial_prb   = err_q;

endmodule
